// File: rtl/spi_ram_arbiter_if.sv
// SPI-slave, host and RAM signal bundle around the SPI RAM arbiter.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8
);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
  logic                 spi_ovf;

  // Arbiter side.
  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );

  // Environment side (SPI slave, host logic and RAM).
  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder sharing a single-port RAM with a host port, round-robin.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TX_HOLD   = 9
) (
  input logic          clk,
  input logic          rst_n,
  spi_ram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_n;

  logic                 r_rx_valid_d;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_spi_pend;
  logic                 r_spi_we;
  logic [7:0]           r_spi_wdata;
  logic                 r_spi_ovf;
  logic                 r_last_host;

  logic                 r_ram_en;
  logic                 r_ram_we;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic [7:0]           r_ram_wdata;
  logic                 r_host_gnt;
  logic [7:0]           r_host_rdata;
  logic                 r_host_rvalid;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic [CNT_W-1:0]     r_tx_cnt;

  logic                 w_rx_rise;
  logic [1:0]           w_cmd;
  logic                 w_spi_acc;
  logic                 w_grant_spi;
  logic                 w_grant_host;
  logic                 w_ram_en_n;
  logic                 w_ram_we_n;
  logic [ADDR_SIZE-1:0] w_ram_addr_n;
  logic [7:0]           w_ram_wdata_n;
  logic                 w_host_gnt_n;
  logic                 w_host_rvalid_n;
  logic                 w_tx_load;

  assign w_rx_rise = bus.rx_valid & ~r_rx_valid_d;
  assign w_cmd     = bus.rx_data[9:8];
  assign w_spi_acc = w_rx_rise & w_cmd[0];

  // SPI word decode: address registers, pending access and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_valid_d <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_spi_pend   <= 1'b0;
      r_spi_we     <= 1'b0;
      r_spi_wdata  <= '0;
      r_spi_ovf    <= 1'b0;
    end else begin
      r_rx_valid_d <= bus.rx_valid;
      if (w_rx_rise && w_cmd == 2'b00) r_wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
      if (w_rx_rise && w_cmd == 2'b10) r_rd_addr <= bus.rx_data[ADDR_SIZE-1:0];
      if (r_state == S_ACCESS && !r_last_host) r_spi_pend <= 1'b0;
      if (w_spi_acc) begin
        if (r_spi_pend || r_tx_valid) begin
          r_spi_ovf <= 1'b1;
        end else begin
          r_spi_pend  <= 1'b1;
          r_spi_we    <= ~w_cmd[1];
          r_spi_wdata <= bus.rx_data[7:0];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Arbitration and next-state decode.
  always_comb begin
    w_grant_spi  = 1'b0;
    w_grant_host = 1'b0;
    w_state_n    = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_spi_pend && bus.host_req) begin
          w_grant_spi  = r_last_host;
          w_grant_host = ~r_last_host;
        end else begin
          w_grant_spi  = r_spi_pend;
          w_grant_host = bus.host_req;
        end
        if (w_grant_spi || w_grant_host) w_state_n = S_ACCESS;
      end
      S_ACCESS:  w_state_n = r_ram_we ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_ram_en_n      = w_grant_spi | w_grant_host;
    w_ram_we_n      = r_ram_we;
    w_ram_addr_n    = r_ram_addr;
    w_ram_wdata_n   = r_ram_wdata;
    w_host_gnt_n    = w_grant_host;
    w_host_rvalid_n = (r_state == S_CAPTURE) & r_last_host;
    w_tx_load       = (r_state == S_CAPTURE) & ~r_last_host;
    if (w_grant_host) begin
      w_ram_we_n    = bus.host_we;
      w_ram_addr_n  = bus.host_addr;
      w_ram_wdata_n = bus.host_wdata;
    end else if (w_grant_spi) begin
      w_ram_we_n    = r_spi_we;
      w_ram_addr_n  = r_spi_we ? r_wr_addr : r_rd_addr;
      w_ram_wdata_n = r_spi_wdata;
    end
  end

  // Output registers, grant history and read-byte hold counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= '0;
      r_host_gnt    <= 1'b0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_cnt      <= '0;
      r_last_host   <= 1'b1;
    end else begin
      r_ram_en      <= w_ram_en_n;
      r_ram_we      <= w_ram_we_n;
      r_ram_addr    <= w_ram_addr_n;
      r_ram_wdata   <= w_ram_wdata_n;
      r_host_gnt    <= w_host_gnt_n;
      r_host_rvalid <= w_host_rvalid_n;
      if (w_grant_spi || w_grant_host) r_last_host <= w_grant_host;
      if (w_host_rvalid_n) r_host_rdata <= bus.ram_rdata;
      if (w_tx_load) begin
        r_tx_data  <= bus.ram_rdata;
        r_tx_valid <= 1'b1;
        r_tx_cnt   <= CNT_W'(TX_HOLD - 1);
      end else if (r_tx_valid) begin
        if (r_tx_cnt == '0) r_tx_valid <= 1'b0;
        else                r_tx_cnt   <= r_tx_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.ram_en      = r_ram_en;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.host_gnt    = r_host_gnt;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.spi_ovf     = r_spi_ovf;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural RAM and access log.
module tb_spi_ram_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   lat;
  int   cnt;

  spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_arbiter #(.ADDR_SIZE(8), .TX_HOLD(9)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: unwritten locations read as addr ^ 0x9E.
  logic [7:0] mem     [256];
  logic       written [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.ram_rdata <= 8'h00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= (written[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                          : (bus.ram_addr ^ 8'h9E);
      end
    end
  end

  // Log of RAM accesses as {addr, wdata}.
  logic [15:0] acc_q[$];
  always @(negedge clk) begin
    if (rst_n && bus.ram_en) acc_q.push_back({bus.ram_addr, bus.ram_wdata});
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_word(input logic [9:0] w);
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  // Raise a host request and hold it until the grant; returns in the grant cycle.
  task automatic host_req_wait(input logic we, input logic [7:0] a, input logic [7:0] d,
                               output int latency);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    latency = 0;
    tick();
    while (!bus.host_gnt && latency < 20) begin
      tick();
      latency++;
    end
    chk("host_gnt_seen", 16'(bus.host_gnt), 16'd1);
    bus.host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    repeat (3) tick();
    chk("rst_ram_en",   16'(bus.ram_en),      16'd0);
    chk("rst_tx_valid", 16'(bus.tx_valid),    16'd0);
    chk("rst_host_gnt", 16'(bus.host_gnt),    16'd0);
    chk("rst_rvalid",   16'(bus.host_rvalid), 16'd0);
    chk("rst_ovf",      16'(bus.spi_ovf),     16'd0);
    chk("rst_ram_addr", 16'(bus.ram_addr),    16'd0);
    rst_n = 1'b1;
    tick();

    // 1: SPI write of 0x3C to 0xA5.
    spi_word(10'h0A5);
    chk("t1_ram_en_pre", 16'(bus.ram_en), 16'd0);
    spi_word(10'h13C);
    chk("t1_ram_en",    16'(bus.ram_en),    16'd1);
    chk("t1_ram_we",    16'(bus.ram_we),    16'd1);
    chk("t1_ram_addr",  16'(bus.ram_addr),  16'h00A5);
    chk("t1_ram_wdata", 16'(bus.ram_wdata), 16'h003C);
    chk("t1_ovf",       16'(bus.spi_ovf),   16'd0);
    tick();
    chk("t1_ram_en_off", 16'(bus.ram_en),   16'd0);
    chk("t1_addr_hold",  16'(bus.ram_addr), 16'h00A5);
    tick();

    // 2: SPI read of 0xC0, RAM returns 0x5E, held 9 cycles on tx.
    spi_word(10'h2C0);
    spi_word(10'h300);
    chk("t2_ram_en",   16'(bus.ram_en),   16'd1);
    chk("t2_ram_we",   16'(bus.ram_we),   16'd0);
    chk("t2_ram_addr", 16'(bus.ram_addr), 16'h00C0);
    tick();
    chk("t2_tx_early", 16'(bus.tx_valid), 16'd0);
    tick();
    chk("t2_tx_valid", 16'(bus.tx_valid), 16'd1);
    chk("t2_tx_data",  16'(bus.tx_data),  16'h005E);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid) cnt++;
      tick();
    end
    chk("t2_tx_hold_cycles", 16'(cnt), 16'd9);
    chk("t2_tx_valid_end",   16'(bus.tx_valid), 16'd0);

    // 3: host read of 0x10 alone; grant at N+1, data at N+3.
    host_req_wait(1'b0, 8'h10, 8'h00, lat);
    chk("t3_gnt_latency", 16'(lat),          16'd0);
    chk("t3_ram_addr",    16'(bus.ram_addr), 16'h0010);
    chk("t3_ram_we",      16'(bus.ram_we),   16'd0);
    tick();
    chk("t3_gnt_pulse",   16'(bus.host_gnt),    16'd0);
    chk("t3_rvalid_n2",   16'(bus.host_rvalid), 16'd0);
    tick();
    chk("t3_rvalid",      16'(bus.host_rvalid), 16'd1);
    chk("t3_rdata",       16'(bus.host_rdata),  16'h008E);
    tick();
    chk("t3_rvalid_pulse", 16'(bus.host_rvalid), 16'd0);

    // Host write then read back through the RAM model.
    host_req_wait(1'b1, 8'h20, 8'h77, lat);
    repeat (3) tick();
    host_req_wait(1'b0, 8'h20, 8'h00, lat);
    tick();
    tick();
    chk("hw_readback_rvalid", 16'(bus.host_rvalid), 16'd1);
    chk("hw_readback_rdata",  16'(bus.host_rdata),  16'h0077);
    repeat (2) tick();

    // 4: simultaneous SPI write and host request; round-robin order.
    spi_word(10'h0B0);
    acc_q.delete();
    for (int r = 0; r < 2; r++) begin
      bus.rx_data  = 10'h150 + 10'(r);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      host_req_wait(1'b1, 8'h40 + 8'(r), 8'hA0 + 8'(r), lat);
      repeat (3) tick();
    end
    chk("t4_access_count", 16'(acc_q.size()), 16'd4);
    if (acc_q.size() >= 4) begin
      chk("t4_grant0_spi",  acc_q[0], 16'hB050);
      chk("t4_grant1_host", acc_q[1], 16'h40A0);
      chk("t4_grant2_spi",  acc_q[2], 16'hB051);
      chk("t4_grant3_host", acc_q[3], 16'h41A1);
    end
    chk("t4_ovf", 16'(bus.spi_ovf), 16'd0);

    // 5: second SPI access word while the first is pending.
    acc_q.delete();
    bus.rx_data = 10'h111;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data = 10'h122;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    chk("t5_ovf_set", 16'(bus.spi_ovf), 16'd1);
    repeat (4) tick();
    chk("t5_one_access",  16'(acc_q.size()), 16'd1);
    if (acc_q.size() >= 1) chk("t5_first_served", acc_q[0], 16'hB011);
    chk("t5_ovf_sticky", 16'(bus.spi_ovf), 16'd1);

    // 6: reset asserted during CAPTURE of a host read.
    host_req_wait(1'b0, 8'h33, 8'h00, lat);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rvalid",     16'(bus.host_rvalid), 16'd0);
    chk("t6_tx_valid",   16'(bus.tx_valid),    16'd0);
    chk("t6_ram_en",     16'(bus.ram_en),      16'd0);
    chk("t6_ovf",        16'(bus.spi_ovf),     16'd0);
    chk("t6_host_rdata", 16'(bus.host_rdata),  16'd0);
    chk("t6_ram_addr",   16'(bus.ram_addr),    16'd0);
    chk("t6_tx_data",    16'(bus.tx_data),     16'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_rvalid_after", 16'(bus.host_rvalid), 16'd0);
    tick();
    chk("t6_rvalid_late",  16'(bus.host_rvalid), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
